// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding and port ids.
package rf_arb_pkg;

   localparam logic [1:0] IDLE_ENC    = 2'd0;
   localparam logic [1:0] ACCESS_ENC  = 2'd1;
   localparam logic [1:0] RD_WAIT_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = IDLE_ENC,
      ACCESS  = ACCESS_ENC,
      RD_WAIT = RD_WAIT_ENC
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rf_arb_rr_pick.sv
// Two-way round-robin picker: a lone request wins; a contested request goes to
// the port that was not granted last.
module rf_arb_rr_pick
   import rf_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any
);

   // Winner selection; winner is only meaningful when any=1.
   always_comb begin
      any    = |req;
      winner = PORT0;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[1]) begin
         winner = PORT1;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a single-port register file between the system
// command controller (port 0) and the config/debug master (port 1). One access
// in flight; reads wait for RF_DATA_VALID with a timeout that completes with RD_ERR.
// Optional feature macro RF_ARB_LOCK_EN: adds LOCK0/LOCK1 so the current owner can
// keep re-winning while it holds its lock and request.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and latches the winner's command
// ACCESS  | one cycle: GNT and RF strobe are out
// RD_WAIT | read issued; waiting for RF_DATA_VALID or timeout
module regfile_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int TIMEOUT_CYC = 15
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0,
   input  logic                  REQ1,
`ifdef RF_ARB_LOCK_EN
   input  logic                  LOCK0,
   input  logic                  LOCK1,
`endif
   input  logic                  WR0,
   input  logic                  WR1,
   input  logic [ADDR_WIDTH-1:0] ADDR0,
   input  logic [ADDR_WIDTH-1:0] ADDR1,
   input  logic [DATA_WIDTH-1:0] WDATA0,
   input  logic [DATA_WIDTH-1:0] WDATA1,
   output logic                  GNT0,
   output logic                  GNT1,
   output logic [DATA_WIDTH-1:0] RDATA0,
   output logic [DATA_WIDTH-1:0] RDATA1,
   output logic                  RVALID0,
   output logic                  RVALID1,
   output logic                  RD_ERR,
   output logic [ADDR_WIDTH-1:0] RF_ADDRESS,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   input  logic [DATA_WIDTH-1:0] RF_RdData,
   input  logic                  RF_DATA_VALID
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic             last_q;
   logic             wr_q;
   logic [CNT_W-1:0] cnt;

   logic             pick_win;
   logic             pick_any;
   logic             winner;
   logic             win_wr;

   rf_arb_rr_pick u_pick (
      .req    ({REQ1, REQ0}),
      .last   (last_q),
      .winner (pick_win),
      .any    (pick_any)
   );

`ifdef RF_ARB_LOCK_EN
   logic lock_hold;
   // The last owner keeps the file while it still requests with its lock set.
   assign lock_hold = (last_q == PORT1) ? (LOCK1 & REQ1) : (LOCK0 & REQ0);
   assign winner    = lock_hold ? last_q : pick_win;
`else
   assign winner    = pick_win;
`endif

   assign win_wr = (winner == PORT1) ? WR1 : WR0;

   // Sequencer: arbitration, command latch, timeout counter and all output registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         last_q     <= PORT1;
         wr_q       <= 1'b0;
         cnt        <= '0;
         GNT0       <= 1'b0;
         GNT1       <= 1'b0;
         RDATA0     <= '0;
         RDATA1     <= '0;
         RVALID0    <= 1'b0;
         RVALID1    <= 1'b0;
         RD_ERR     <= 1'b0;
         RF_ADDRESS <= '0;
         RF_WrEn    <= 1'b0;
         RF_RdEn    <= 1'b0;
         RF_WrData  <= '0;
      end else begin
         GNT0    <= 1'b0;
         GNT1    <= 1'b0;
         RF_WrEn <= 1'b0;
         RF_RdEn <= 1'b0;
         RVALID0 <= 1'b0;
         RVALID1 <= 1'b0;
         RD_ERR  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  last_q     <= winner;
                  wr_q       <= win_wr;
                  RF_ADDRESS <= (winner == PORT1) ? ADDR1 : ADDR0;
                  if (win_wr) begin
                     RF_WrData <= (winner == PORT1) ? WDATA1 : WDATA0;
                  end
                  GNT0    <= (winner == PORT0);
                  GNT1    <= (winner == PORT1);
                  RF_WrEn <= win_wr;
                  RF_RdEn <= ~win_wr;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               cnt   <= '0;
               state <= wr_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               // Valid data takes priority over a timeout in the same cycle.
               if (RF_DATA_VALID || (cnt == CNT_LAST)) begin
                  if (last_q == PORT1) begin
                     RDATA1  <= RF_DATA_VALID ? RF_RdData : '0;
                     RVALID1 <= 1'b1;
                  end else begin
                     RDATA0  <= RF_DATA_VALID ? RF_RdData : '0;
                     RVALID0 <= 1'b1;
                  end
                  RD_ERR <= ~RF_DATA_VALID;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a grant/read-completion scoreboard.
// Build with RF_ARB_LOCK_EN defined to also exercise the lock feature.
module tb_regfile_arbiter;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 15;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          REQ0 = 1'b0, REQ1 = 1'b0;
`ifdef RF_ARB_LOCK_EN
   logic          LOCK0 = 1'b0, LOCK1 = 1'b0;
`endif
   logic          WR0 = 1'b0, WR1 = 1'b0;
   logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
   logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
   logic          GNT0, GNT1;
   logic [DW-1:0] RDATA0, RDATA1;
   logic          RVALID0, RVALID1, RD_ERR;
   logic [AW-1:0] RF_ADDRESS;
   logic          RF_WrEn, RF_RdEn;
   logic [DW-1:0] RF_WrData;
   logic [DW-1:0] RF_RdData = '0;
   logic          RF_DATA_VALID = 1'b0;

   always #5 CLK = ~CLK;

   regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .REQ0          (REQ0),
      .REQ1          (REQ1),
`ifdef RF_ARB_LOCK_EN
      .LOCK0         (LOCK0),
      .LOCK1         (LOCK1),
`endif
      .WR0           (WR0),
      .WR1           (WR1),
      .ADDR0         (ADDR0),
      .ADDR1         (ADDR1),
      .WDATA0        (WDATA0),
      .WDATA1        (WDATA1),
      .GNT0          (GNT0),
      .GNT1          (GNT1),
      .RDATA0        (RDATA0),
      .RDATA1        (RDATA1),
      .RVALID0       (RVALID0),
      .RVALID1       (RVALID1),
      .RD_ERR        (RD_ERR),
      .RF_ADDRESS    (RF_ADDRESS),
      .RF_WrEn       (RF_WrEn),
      .RF_RdEn       (RF_RdEn),
      .RF_WrData     (RF_WrData),
      .RF_RdData     (RF_RdData),
      .RF_DATA_VALID (RF_DATA_VALID)
   );

   typedef struct packed {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } gexp_t;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
      logic          err;
   } rexp_t;

   gexp_t exp_g[$];
   rexp_t exp_r[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int gnt_total = 0;
   int rv_total = 0;
   int last_gnt_cyc = 0;
   int last_rv_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock step; outputs sampled 1 time unit after the edge and scored.
   task automatic tick();
      gexp_t g;
      rexp_t r;
      @(posedge CLK);
      #1;
      cyc++;
      if (GNT0 || GNT1) begin
         gnt_total++;
         last_gnt_cyc = cyc;
         if (exp_g.size() == 0) begin
            chk("gnt_unexpected", 0, 1);
         end else begin
            g = exp_g.pop_front();
            chk("gnt0", GNT0, !g.port);
            chk("gnt1", GNT1, g.port);
            chk("rf_wren", RF_WrEn, g.wr);
            chk("rf_rden", RF_RdEn, !g.wr);
            chk("rf_addr", RF_ADDRESS, g.addr);
            if (g.wr) chk("rf_wdata", RF_WrData, g.data);
         end
      end else begin
         chk("strobe_idle", {RF_WrEn, RF_RdEn}, 0);
      end
      if (RVALID0 || RVALID1) begin
         rv_total++;
         last_rv_cyc = cyc;
         if (exp_r.size() == 0) begin
            chk("rvalid_unexpected", 0, 1);
         end else begin
            r = exp_r.pop_front();
            chk("rvalid0", RVALID0, !r.port);
            chk("rvalid1", RVALID1, r.port);
            chk("rdata", r.port ? RDATA1 : RDATA0, r.data);
            chk("rd_err", RD_ERR, r.err);
         end
      end else begin
         chk("rd_err_idle", RD_ERR, 0);
      end
   endtask

   task automatic wait_gnt(input int target, input int budget);
      int n = 0;
      while (gnt_total < target && n < budget) begin
         tick();
         n++;
      end
      if (gnt_total < target) chk("gnt_wait_timeout", gnt_total, target);
   endtask

   task automatic wait_rv(input int target, input int budget);
      int n = 0;
      while (rv_total < target && n < budget) begin
         tick();
         n++;
      end
      if (rv_total < target) chk("rvalid_wait_timeout", rv_total, target);
   endtask

   task automatic drive_req(input logic port, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
      if (port) begin
         REQ1 = 1'b1; WR1 = wr; ADDR1 = addr; WDATA1 = data;
      end else begin
         REQ0 = 1'b1; WR0 = wr; ADDR0 = addr; WDATA0 = data;
      end
   endtask

   task automatic release_req(input logic port);
      if (port) REQ1 = 1'b0;
      else REQ0 = 1'b0;
   endtask

   task automatic push_gnt(input logic port, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
      gexp_t g;
      g.port = port; g.wr = wr; g.addr = addr; g.data = data;
      exp_g.push_back(g);
   endtask

   task automatic do_write(input logic port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int c0;
      push_gnt(port, 1'b1, addr, data);
      drive_req(port, 1'b1, addr, data);
      c0 = cyc;
      wait_gnt(gnt_total + 1, 20);
      chk("write_gnt_latency", last_gnt_cyc - c0, 1);
      release_req(port);
   endtask

   // vdelay < 0: RF_DATA_VALID never comes, a timeout completion is expected.
   task automatic do_read(input logic port, input logic [AW-1:0] addr, input int vdelay,
                          input logic [DW-1:0] rdata);
      rexp_t r;
      int c;
      int t;
      push_gnt(port, 1'b0, addr, '0);
      r.port = port;
      r.data = (vdelay < 0) ? '0 : rdata;
      r.err  = (vdelay < 0);
      exp_r.push_back(r);
      drive_req(port, 1'b0, addr, '0);
      wait_gnt(gnt_total + 1, 20);
      c = cyc;
      release_req(port);
      t = rv_total + 1;
      if (vdelay >= 0) begin
         repeat (vdelay) tick();
         RF_DATA_VALID = 1'b1;
         RF_RdData     = rdata;
         tick();
         RF_DATA_VALID = 1'b0;
         RF_RdData     = '0;
         chk("read_rvalid_latency", last_rv_cyc - c, vdelay + 1);
      end
      wait_rv(t, TO + 10);
      if (vdelay < 0) chk("timeout_latency", last_rv_cyc - c, TO + 1);
   endtask

   initial begin
      int base;
      int prev;

      // Reset state
      tick();
      tick();
      chk("reset_ctrl", {GNT0, GNT1, RVALID0, RVALID1, RD_ERR, RF_WrEn, RF_RdEn}, 0);
      chk("reset_data", {RF_ADDRESS, RF_WrData, RDATA0, RDATA1}, 0);
      RST = 1'b1;
      tick();

      // 1: port 0 write, addr 3, data 0x5A
      do_write(1'b0, 4'd3, 8'h5A);
      tick();

      // 2: port 1 read, addr 3, valid 2 cycles after RdEn
      do_read(1'b1, 4'd3, 2, 8'h5A);
      tick();

      // 3: both ports requesting writes continuously: strict alternation
      push_gnt(1'b0, 1'b1, 4'd1, 8'h11);
      push_gnt(1'b1, 1'b1, 4'd2, 8'h22);
      push_gnt(1'b0, 1'b1, 4'd1, 8'h11);
      push_gnt(1'b1, 1'b1, 4'd2, 8'h22);
      drive_req(1'b0, 1'b1, 4'd1, 8'h11);
      drive_req(1'b1, 1'b1, 4'd2, 8'h22);
      base = gnt_total;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(base + i + 1, 10);
         if (i > 0) chk("b2b_spacing", last_gnt_cyc - prev, 2);
         prev = last_gnt_cyc;
      end
      release_req(1'b0);
      release_req(1'b1);
      tick();
      tick();

      // Port 0 read with the earliest useful valid, then a timeout read on port 0
      do_read(1'b0, 4'd6, 1, 8'hC3);
      tick();
      // Valid landing on the timeout cycle: data wins
      do_read(1'b1, 4'd8, TO, 8'h7E);
      tick();
      // 4: no valid at all -> error completion, RDATA0 cleared
      do_read(1'b0, 4'd7, -1, '0);
      tick();
      chk("rdata1_hold", RDATA1, 8'h7E);

      // RF_DATA_VALID outside RD_WAIT is ignored
      prev = rv_total;
      RF_DATA_VALID = 1'b1;
      RF_RdData     = 8'hFF;
      tick();
      RF_DATA_VALID = 1'b0;
      RF_RdData     = '0;
      tick();
      tick();
      chk("idle_valid_ignored", rv_total, prev);

      // 5: reset in RD_WAIT of a port 0 read
      push_gnt(1'b0, 1'b0, 4'd5, '0);
      drive_req(1'b0, 1'b0, 4'd5, '0);
      wait_gnt(gnt_total + 1, 20);
      release_req(1'b0);
      tick();
      tick();
      tick();
      RST = 1'b0;
      tick();
      chk("midrst_ctrl", {GNT0, GNT1, RVALID0, RVALID1, RD_ERR, RF_WrEn, RF_RdEn}, 0);
      chk("midrst_data", {RF_ADDRESS, RF_WrData, RDATA0, RDATA1}, 0);
      RST = 1'b1;
      tick();
      prev = rv_total;
      push_gnt(1'b0, 1'b1, 4'd9, 8'h99);
      push_gnt(1'b1, 1'b1, 4'hA, 8'hAA);
      drive_req(1'b0, 1'b1, 4'd9, 8'h99);
      drive_req(1'b1, 1'b1, 4'hA, 8'hAA);
      wait_gnt(gnt_total + 1, 10);
      release_req(1'b0);
      wait_gnt(gnt_total + 1, 10);
      release_req(1'b1);
      repeat (20) tick();
      chk("no_rvalid_after_reset", rv_total, prev);

`ifdef RF_ARB_LOCK_EN
      // 6: port 1 locked over three writes while port 0 waits
      push_gnt(1'b1, 1'b1, 4'hC, 8'h3C);
      push_gnt(1'b1, 1'b1, 4'hC, 8'h3C);
      push_gnt(1'b1, 1'b1, 4'hC, 8'h3C);
      push_gnt(1'b0, 1'b1, 4'hD, 8'h4D);
      LOCK1 = 1'b1;
      drive_req(1'b1, 1'b1, 4'hC, 8'h3C);
      wait_gnt(gnt_total + 1, 10);
      drive_req(1'b0, 1'b1, 4'hD, 8'h4D);
      wait_gnt(gnt_total + 2, 10);
      LOCK1 = 1'b0;
      release_req(1'b1);
      wait_gnt(gnt_total + 1, 10);
      release_req(1'b0);
      repeat (3) tick();
`endif

      chk("gnt_queue_drained", exp_g.size(), 0);
      chk("rd_queue_drained", exp_r.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
